// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit 1, WIDTH data bits LSB first, stop bit 0.
// Good words land in a one-entry valid/ready holding register; framing errors pulse, drops set a sticky overflow.
module serial_frame_rx #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             bit_in,
    input  logic             bit_en,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             frame_err,
    output logic             overflow,
    input  logic             clear_overflow
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_STOP} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             vld_q, vld_d;
    logic             ferr_q, ferr_d;
    logic             ovf_q, ovf_d;
    logic             good_stop;
    logic             drain;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
            dout_q  <= '0;
            vld_q   <= 1'b0;
            ferr_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
            ferr_q  <= ferr_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        buf_d     = buf_q;
        dout_d    = dout_q;
        vld_d     = vld_q;
        ferr_d    = 1'b0;
        ovf_d     = ovf_q;
        good_stop = 1'b0;
        drain     = vld_q && data_ready;

        if (bit_en) begin
            case (state_q)
                S_IDLE: if (bit_in) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end
                S_DATA: begin
                    buf_d[cnt_q] = bit_in;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = S_STOP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    // A 1 in the stop slot is an error, never a fresh start bit.
                    state_d = S_IDLE;
                    if (bit_in) ferr_d = 1'b1;
                    else        good_stop = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (drain)          vld_d = 1'b0;
        if (clear_overflow) ovf_d = 1'b0;
        // Load may reuse the slot being drained on this edge; set beats clear.
        if (good_stop) begin
            if (!vld_q || drain) begin
                dout_d = buf_q;
                vld_d  = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    assign data_out   = dout_q;
    assign data_valid = vld_q;
    assign frame_err  = ferr_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed plus randomized checks of serial_frame_rx against a frame-level reference model.
module tb_serial_frame_rx;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         bit_in = 1'b0;
    logic         bit_en = 1'b0;
    logic         data_ready = 1'b0;
    logic         clear_overflow = 1'b0;
    logic [W-1:0] data_out;
    logic         data_valid;
    logic         frame_err;
    logic         overflow;

    serial_frame_rx #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .bit_in(bit_in), .bit_en(bit_en),
        .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
        .frame_err(frame_err), .overflow(overflow), .clear_overflow(clear_overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference: holding register contents plus sticky/pulse flags, updated per sampled edge.
    logic [W-1:0] m_data  = '0;
    logic         m_valid = 1'b0;
    logic         m_ovf   = 1'b0;
    logic         m_ferr  = 1'b0;
    logic         rand_ctl = 1'b0;
    logic         rdy_at_stop = 1'b0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("data_valid", {{(W-1){1'b0}}, data_valid}, {{(W-1){1'b0}}, m_valid});
        chk("data_out",   data_out, m_data);
        chk("frame_err",  {{(W-1){1'b0}}, frame_err}, {{(W-1){1'b0}}, m_ferr});
        chk("overflow",   {{(W-1){1'b0}}, overflow},  {{(W-1){1'b0}}, m_ovf});
    endtask

    // kind: 0 ordinary bit, 1 good stop delivering word, 2 bad stop
    task automatic step(input logic en, input logic b, input int kind, input logic [W-1:0] word);
        logic load, drain, set;
        bit_en = en;
        bit_in = b;
        if (rand_ctl) begin
            data_ready     = 1'($urandom_range(0, 1));
            clear_overflow = ($urandom_range(0, 7) == 0);
        end
        @(posedge clk);
        load   = en && (kind == 1);
        drain  = m_valid && data_ready;
        set    = 1'b0;
        m_ferr = en && (kind == 2);
        if (drain) m_valid = 1'b0;
        if (load) begin
            if (!m_valid) begin
                m_valid = 1'b1;
                m_data  = word;
            end else begin
                set = 1'b1;
            end
        end
        if (clear_overflow) m_ovf = 1'b0;
        if (set)            m_ovf = 1'b1;
        #1 check_all();
    endtask

    // gapmode: 0 none, 1 alternate bit_en, 2 random gaps of 0..2 cycles
    task automatic send_frame(input logic [W-1:0] w, input logic stopb, input int gapmode);
        logic [W-1:0] sh;
        logic         b;
        int           kind;
        sh = w;
        for (int i = 0; i < W + 2; i++) begin
            kind = 0;
            if (i == 0) b = 1'b1;
            else if (i == W + 1) begin
                b    = stopb;
                kind = stopb ? 2 : 1;
            end else begin
                b  = sh[0];
                sh = sh >> 1;
            end
            if (gapmode == 2) repeat ($urandom_range(0, 2)) step(1'b0, 1'($urandom_range(0, 1)), 0, '0);
            if (i == W + 1 && rdy_at_stop) data_ready = 1'b1;
            step(1'b1, b, kind, w);
            if (gapmode == 1) step(1'b0, 1'($urandom_range(0, 1)), 0, '0);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 1'b0, 0, '0);
    endtask

    task automatic do_reset();
        bit_en  = 1'b0;
        reset_n = 1'b0;
        #2;
        m_data = '0; m_valid = 1'b0; m_ovf = 1'b0; m_ferr = 1'b0;
        check_all();
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] w;
        do_reset();

        // Basic receive of 0x5
        data_ready = 1'b1;
        send_frame(4'h5, 1'b0, 0);
        idle(2);

        // Framing error, then a clean 0x3
        send_frame(4'hF, 1'b1, 0);
        idle(1);
        send_frame(4'h3, 1'b0, 0);
        idle(2);

        // Backpressure and overflow
        data_ready = 1'b0;
        send_frame(4'h9, 1'b0, 0);
        send_frame(4'h6, 1'b0, 0);
        idle(1);
        data_ready = 1'b1;
        idle(1);
        data_ready = 1'b0;
        idle(1);
        clear_overflow = 1'b1;
        idle(1);
        clear_overflow = 1'b0;
        idle(1);

        // Simultaneous drain and load
        send_frame(4'hA, 1'b0, 0);
        idle(1);
        rdy_at_stop = 1'b1;
        send_frame(4'hC, 1'b0, 0);
        rdy_at_stop = 1'b0;
        idle(2);

        // Gapped frame, then reset mid-frame
        send_frame(4'hF, 1'b0, 1);
        idle(2);
        step(1'b1, 1'b1, 0, '0);
        step(1'b1, 1'b1, 0, '0);
        step(1'b1, 1'b0, 0, '0);
        do_reset();
        send_frame(4'h1, 1'b0, 0);
        idle(2);

        // Randomized traffic: random words, stop errors, gaps, backpressure and clears
        rand_ctl = 1'b1;
        for (int f = 0; f < 80; f++) begin
            w = W'($urandom_range(0, (1 << W) - 1));
            send_frame(w, ($urandom_range(0, 5) == 0), 2);
            idle($urandom_range(0, 2));
        end
        rand_ctl       = 1'b0;
        data_ready     = 1'b1;
        clear_overflow = 1'b1;
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_frame_rx.md
# serial_frame_rx

Serial-to-parallel frame receiver that consumes the bit stream leaving the 4-bit shift register's `serial_out`. It samples one bit per `bit_en` strobe and detects a start bit. It then assembles WIDTH data bits LSB-first and checks a stop bit. Each good word is delivered through a one-entry valid/ready holding register, with framing-error and overflow reporting.

## Interface
- WIDTH, 4, data bits per frame (≥2)
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- bit_in  input  1  serial data (idle level 0)
- bit_en  input  1  bit_in is sampled on a clk edge only when bit_en=1
- data_out  output  WIDTH  received word, stable while data_valid=1
- data_valid  output  1  holding register occupied
- data_ready  input  1  consumer accepts word when data_valid&&data_ready at a clk edge
- frame_err  output  1  one-cycle pulse: stop bit sampled as 1
- overflow  output  1  sticky: good word dropped because holding register full
- clear_overflow  input  1  synchronous clear of overflow

## Operation
- Reset (reset_n=0, async): state=IDLE, bit counter=0, shift buffer=0, data_out=0, data_valid=0, frame_err=0, overflow=0.
- All state changes below occur only on edges where bit_en=1, except handshake, frame_err clear and overflow clear.
- Frame format: start bit 1, then WIDTH data bits LSB first, then stop bit 0. Total WIDTH+2 sampled bits.
- FSM:
  - IDLE: bit_in=1 -> DATA, counter=0. bit_in=0 -> stay.
  - DATA: the sampled bit goes to buffer[counter], counter++. After the WIDTH-th data bit -> STOP.
  - STOP: bit_in=0 -> good frame, deliver buffer, go to IDLE. bit_in=1 -> frame_err pulse, discard buffer, go to IDLE (this 1 is NOT taken as a new start bit).
- Delivery of a good frame:
  - Holding register empty, or being drained on the same edge (data_valid&&data_ready): load data_out and set data_valid=1.
  - Otherwise: the word is dropped and overflow is set. data_out is unchanged.
- Handshake:
  - data_valid&&data_ready with no simultaneous load -> data_valid=0. data_out holds its last value.
  - data_valid must not drop without acceptance.
  - data_ready while data_valid=0 has no effect.
- Overflow:
  - clear_overflow=1 clears it.
  - If clear and a new overflow occur on the same edge, overflow=1 (set wins).
- frame_err is high for exactly the one cycle after the offending stop-bit edge, then 0.
- Gaps (bit_en=0 for any number of cycles) mid-frame are legal. State and counter are held.
- Counter width is $clog2(WIDTH) (minimum 1). It never exceeds WIDTH-1.

## Timing
- Sampling happens on rising clk with bit_en=1. Outputs are registered.
- Latency: data_valid and data_out update right after the edge that samples the good stop bit, i.e. visible in the next cycle.
- With bit_en=1 every cycle, a frame occupies WIDTH+2 cycles. Back-to-back frames (start bit on the cycle after stop) are accepted at full rate if the consumer holds data_ready=1.
- Throughput: one word per WIDTH+2 sampled bits. The holding register is not a bottleneck when data_ready=1.
- Reset asserted mid-frame aborts the frame immediately. No partial word is ever delivered.
- Reset deassertion is asynchronous in assertion only. The first sample is taken on the first clk edge with reset_n=1.

## Test plan
- Basic receive:
  - Stimulus: WIDTH=4, bit_en=1 constant, data_ready=1; bits 1,1,0,1,0,0 (start, data LSB-first 1011b→0x5? no: bits d0..d3=1,0,1,0 →0x5), stop 0.
  - Required: data_out=4'h5 with data_valid=1 for one cycle, frame_err=0.
- Framing error:
  - Stimulus: start, data 1,1,1,1, stop=1.
  - Required: frame_err pulses 1 cycle, data_valid stays 0, FSM returns to IDLE. A following clean frame carrying 0x3 is received correctly.
- Backpressure/overflow:
  - Stimulus: data_ready=0; send frames 0x9 then 0x6.
  - Required: data_out=0x9, data_valid=1, overflow=1 after the second stop. Raising data_ready yields 0x9 once. clear_overflow=1 then clears overflow.
- Simultaneous drain and load:
  - Stimulus: data_valid=1 holding 0xA; raise data_ready on the same edge a good stop for 0xC is sampled.
  - Required: 0xA is accepted, data_out=0xC with data_valid=1, overflow=0.
- Gapped bits and reset mid-frame:
  - Stimulus: bit_en toggles 1/0 each cycle for a frame with 0xF; the received word is 0xF. Then start a frame, send 2 data bits, and pulse reset_n=0.
  - Required: after reset all outputs are 0 and the next full frame 0x1 is received correctly.
